// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Optional stall counter in pipe_hazard_ctrl is enabled by HAZARD_STALL_CNT_EN.
package pipe_pkg;

   typedef enum logic {
      HZ_RUN  = 1'b0,
      HZ_HALT = 1'b1
   } hz_state_e;

   localparam int MD_LATENCY_DEF = 32;

   typedef struct packed {
      logic pc_we;
      logic ifid_we;
      logic ifid_flush;
      logic idex_we;
      logic idex_flush;
      logic exmem_we;
      logic memwb_we;
   } ctrl_bus_t;

   // Canonical control patterns, field order as in ctrl_bus_t
   localparam ctrl_bus_t CTRL_RESET  = 7'b0010100;
   localparam ctrl_bus_t CTRL_RUN    = 7'b1101011;
   localparam ctrl_bus_t CTRL_FREEZE = 7'b0000000;
   localparam ctrl_bus_t CTRL_BRANCH = 7'b1111111;
   localparam ctrl_bus_t CTRL_FRONT  = 7'b0001111;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Occupancy counter for a multi-cycle unit: load to LATENCY, count down to zero.
module md_busy_counter
   import pipe_pkg::*;
#(
   parameter int LATENCY = MD_LATENCY_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic busy_o
);

   localparam int CW = $clog2(LATENCY + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(LATENCY);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freeze, branch flush, front stall, halt FSM.
// Define HAZARD_STALL_CNT_EN to build the front-end stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEF,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bubble_req,
   input  logic             branch_taken,
   input  logic             md_start,
   input  logic             md_use,
   input  logic             mem_wait,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_flush,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             md_busy,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);

   hz_state_e state_q;
   ctrl_bus_t ctrl;
   logic      md_busy_raw;
   logic      md_load;
   logic      go_halt;
   logic      front_stall;

   md_busy_counter #(
      .LATENCY (MD_LATENCY)
   ) u_md_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (md_load),
      .busy_o (md_busy_raw)
   );

   assign go_halt = (state_q == HZ_RUN) && halt_req && !mem_wait && !branch_taken;

   // A bubble beats a mul/div issue; the ID instruction simply retries next cycle
   assign md_load = md_start && !md_busy_raw && !mem_wait && !branch_taken &&
                    !bubble_req && (state_q == HZ_RUN) && !rst;

   assign front_stall = bubble_req || (md_use && md_busy_raw) || (md_start && md_busy_raw) ||
                        (state_q == HZ_HALT) || go_halt;

   always_comb begin
      ctrl = CTRL_RUN;
      if (rst) begin
         ctrl = CTRL_RESET;
      end else if (mem_wait) begin
         ctrl = CTRL_FREEZE;
      end else if (branch_taken) begin
         ctrl = CTRL_BRANCH;
      end else if (front_stall) begin
         ctrl = CTRL_FRONT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HZ_RUN;
      end else begin
         case (state_q)
            HZ_RUN:  if (go_halt) state_q <= HZ_HALT;
            HZ_HALT: if (resume)  state_q <= HZ_RUN;
         endcase
      end
   end

   assign pc_we      = ctrl.pc_we;
   assign ifid_we    = ctrl.ifid_we;
   assign ifid_flush = ctrl.ifid_flush;
   assign idex_we    = ctrl.idex_we;
   assign idex_flush = ctrl.idex_flush;
   assign exmem_we   = ctrl.exmem_we;
   assign memwb_we   = ctrl.memwb_we;
   assign md_busy    = md_busy_raw && !rst;
   assign halted     = (state_q == HZ_HALT) && !rst;

`ifdef HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q;

   // Only RUN-state stalls count; HALT cycles are deliberate, not hazards
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (!ctrl.pc_we && (state_q == HZ_RUN)) begin
         stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MD_LATENCY=4; one task per scenario.
module tb_pipe_hazard_ctrl;

   localparam int LAT = 4;
   localparam int CW  = 8;

   // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we}
   localparam logic [6:0] C_RESET  = 7'b0010100;
   localparam logic [6:0] C_RUN    = 7'b1101011;
   localparam logic [6:0] C_FREEZE = 7'b0000000;
   localparam logic [6:0] C_BRANCH = 7'b1111111;
   localparam logic [6:0] C_FRONT  = 7'b0001111;

   logic clk = 1'b0;
   logic rst, bubble_req, branch_taken, md_start, md_use, mem_wait, halt_req, resume;
   logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we, md_busy, halted;
   logic [CW-1:0] stall_cycles;
   logic [8:0]    obs;
   logic [8:0]    exp_v;
   logic [CW-1:0] exp_s;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .MD_LATENCY (LAT),
      .CNT_W      (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bubble_req   (bubble_req),
      .branch_taken (branch_taken),
      .md_start     (md_start),
      .md_use       (md_use),
      .mem_wait     (mem_wait),
      .halt_req     (halt_req),
      .resume       (resume),
      .pc_we        (pc_we),
      .ifid_we      (ifid_we),
      .ifid_flush   (ifid_flush),
      .idex_we      (idex_we),
      .idex_flush   (idex_flush),
      .exmem_we     (exmem_we),
      .memwb_we     (memwb_we),
      .md_busy      (md_busy),
      .halted       (halted),
      .stall_cycles (stall_cycles)
   );

   assign obs = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we, md_busy, halted};

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bubble_req = 0; branch_taken = 0; md_start = 0; md_use = 0;
      mem_wait = 0; halt_req = 0; resume = 0;
   endtask

   function automatic logic [CW-1:0] stall_exp(input int n);
`ifdef HAZARD_STALL_CNT_EN
      return CW'(n);
`else
      return CW'(n * 0);
`endif
   endfunction

   task automatic test_reset();
      rst = 1; clear_inputs();
      tick();
      tick();
      exp_v = {C_RESET, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_outputs got %b expected %b", obs, exp_v);
      end
      rst = 0;
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL idle_after_reset got %b expected %b", obs, exp_v);
      end
      $display("[TB] reset/idle checked");
   endtask

   task automatic test_bubble();
      bubble_req = 1;
      #1;
      exp_v = {C_FRONT, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL bubble_stall got %b expected %b", obs, exp_v);
      end
      tick();
      bubble_req = 0;
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL bubble_release got %b expected %b", obs, exp_v);
      end
      $display("[TB] single bubble checked");
   endtask

   task automatic test_md_use();
      md_start = 1;
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL md_accept got %b expected %b", obs, exp_v);
      end
      tick();
      md_start = 0; md_use = 1;
      for (int i = 0; i < LAT; i++) begin
         #1;
         exp_v = {C_FRONT, 2'b10};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL md_use_stall[%0d] got %b expected %b", i, obs, exp_v);
         end
         tick();
      end
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL md_use_proceed got %b expected %b", obs, exp_v);
      end
      tick();
      md_use = 0;
      $display("[TB] mul/div occupancy with md_use checked");
   endtask

   task automatic test_back_to_back();
      bubble_req = 1; md_start = 1;
      #1;
      exp_v = {C_FRONT, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL bubble_vs_md got %b expected %b", obs, exp_v);
      end
      tick();
      bubble_req = 0;
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL md_retry_accept got %b expected %b", obs, exp_v);
      end
      tick();
      #1;
      exp_v = {C_FRONT, 2'b10};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL md_start_while_busy got %b expected %b", obs, exp_v);
      end
      md_start = 0;
      for (int i = 0; i < LAT; i++) tick();
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL md_drain got %b expected %b", obs, exp_v);
      end
      $display("[TB] bubble vs md_start retry checked");
   endtask

   task automatic test_branch_priority();
      md_start = 1;
      tick();
      md_start = 0;
      branch_taken = 1; bubble_req = 1; md_use = 1;
      #1;
      exp_v = {C_BRANCH, 2'b10};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL branch_overrides got %b expected %b", obs, exp_v);
      end
      tick();
      clear_inputs();
      for (int i = 0; i < LAT; i++) tick();
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL branch_drain got %b expected %b", obs, exp_v);
      end
      $display("[TB] branch priority checked");
   endtask

   task automatic test_freeze();
      md_start = 1;
      tick();
      md_start = 0; mem_wait = 1; branch_taken = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         exp_v = {C_FREEZE, 2'b10};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL freeze[%0d] got %b expected %b", i, obs, exp_v);
         end
         tick();
      end
      mem_wait = 0;
      #1;
      exp_v = {C_BRANCH, 2'b10};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL branch_after_freeze got %b expected %b", obs, exp_v);
      end
      tick();
      branch_taken = 0;
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL md_count_in_freeze got %b expected %b", obs, exp_v);
      end
      $display("[TB] mem_wait freeze checked");
   endtask

   task automatic test_halt();
      mem_wait = 1; halt_req = 1;
      #1;
      exp_v = {C_FREEZE, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL halt_during_freeze got %b expected %b", obs, exp_v);
      end
      tick();
      mem_wait = 0;
      #1;
      exp_v = {C_FRONT, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL halt_entry got %b expected %b", obs, exp_v);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         #1;
         exp_v = {C_FRONT, 2'b01};
         tests_run++;
         if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL halted[%0d] got %b expected %b", i, obs, exp_v);
         end
         tick();
      end
      halt_req = 0; resume = 1;
      #1;
      exp_v = {C_FRONT, 2'b01};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL resume_cycle got %b expected %b", obs, exp_v);
      end
      tick();
      resume = 0;
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL after_resume got %b expected %b", obs, exp_v);
      end
      $display("[TB] halt/resume checked");
   endtask

   task automatic test_reset_mid();
      md_start = 1;
      tick();
      md_start = 0; halt_req = 1;
      tick();
      halt_req = 0; rst = 1;
      #1;
      exp_v = {C_RESET, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs got %b expected %b", obs, exp_v);
      end
      tick();
      rst = 0;
      #1;
      exp_v = {C_RUN, 2'b00};
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL reset_mid_abandon got %b expected %b", obs, exp_v);
      end
      $display("[TB] reset mid-operation checked");
   endtask

   task automatic test_stall_cnt();
      rst = 1; clear_inputs();
      tick();
      rst = 0;
      #1;
      exp_s = stall_exp(0);
      tests_run++;
      if (stall_cycles !== exp_s) begin
         tests_failed++;
         $display("FAIL stall_cnt_reset got %0d expected %0d", stall_cycles, exp_s);
      end
      bubble_req = 1;
      tick();
      tick();
      bubble_req = 0;
      #1;
      exp_s = stall_exp(2);
      tests_run++;
      if (stall_cycles !== exp_s) begin
         tests_failed++;
         $display("FAIL stall_cnt_bubble got %0d expected %0d", stall_cycles, exp_s);
      end
      halt_req = 1;
      tick();
      halt_req = 0;
      tick();
      resume = 1;
      tick();
      resume = 0;
      #1;
      exp_s = stall_exp(3);
      tests_run++;
      if (stall_cycles !== exp_s) begin
         tests_failed++;
         $display("FAIL stall_cnt_halt got %0d expected %0d", stall_cycles, exp_s);
      end
      mem_wait = 1;
      tick();
      mem_wait = 0;
      #1;
      exp_s = stall_exp(4);
      tests_run++;
      if (stall_cycles !== exp_s) begin
         tests_failed++;
         $display("FAIL stall_cnt_freeze got %0d expected %0d", stall_cycles, exp_s);
      end
      $display("[TB] stall counter checked");
   endtask

   initial begin
      test_reset();
      test_bubble();
      test_md_use();
      test_back_to_back();
      test_branch_priority();
      test_freeze();
      test_halt();
      test_reset_mid();
      test_stall_cnt();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
